pr_ex_mem_v2: RTL and testbench

Parametrised EX/MEM pipeline register for the MIPS pipelined processor. It adds synchronous reset, stall (hold), flush (bubble insert), a per-stage valid bit and a 3-way write-destination select (rt / rd / $31 for JAL). It also carries store data and the link PC into MEM, and exposes a registered forwarding tap for the hazard unit.
Latency is 1 cycle from EX inputs to MEM outputs.

---
 rtl/pr_ex_mem_v2_pkg.sv | 23 ++
 rtl/pr_ex_mem_v2_wdest_sel.sv | 33 +++
 rtl/pr_ex_mem_v2.sv | 165 ++++++++++++++++
 tb/tb_pr_ex_mem_v2.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pr_ex_mem_v2_pkg.sv
// pipe_defs: shared encodings, instruction field offsets and default widths
// for the EX/MEM and MEM/WB pipeline registers.
package pipe_defs;

  // reg_dst encodings; 2'b11 is reserved and treated like REGDST_RT
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;

  // MIPS R/I-type destination field positions
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // default widths
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_RA_W     = 5;
  localparam int DEF_LINK_REG = 31;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/pr_ex_mem_v2_wdest_sel.sv
// wdest_sel: picks the write-back register index (rt / rd / link register)
// and flags a $0 destination. Purely combinational; reused by MEM/WB.
module wdest_sel
  import pipe_defs::*;
#(
  parameter int RA_W     = DEF_RA_W,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic [1:0]           reg_dst,
  input  logic [RT_HI:RD_LO]   instr,      // only the rt..rd field span is needed
  output logic [RA_W-1:0]      dest,
  output logic                 dest_is_zero
);

  logic [RT_HI-RT_LO:0] rt_field;
  logic [RD_HI-RD_LO:0] rd_field;

  assign rt_field = instr[RT_HI:RT_LO];
  assign rd_field = instr[RD_HI:RD_LO];

  // Destination mux; the reserved code falls back to rt
  always_comb begin
    dest = RA_W'(rt_field);
    case (reg_dst)
      REGDST_RD:   dest = RA_W'(rd_field);
      REGDST_LINK: dest = RA_W'(LINK_REG);
      default:     dest = RA_W'(rt_field);
    endcase
  end

  assign dest_is_zero = (dest == '0);

endmodule

// File: rtl/pr_ex_mem_v2.sv
// pr_ex_mem_v2: EX/MEM pipeline register with synchronous reset, flush
// (bubble), stall (hold), valid bit, destination select and forwarding tap.
// Optional performance counters are built when EX_MEM_PERF_CNT_EN is defined;
// otherwise bubble_cnt/stall_cnt read as zero.
module pr_ex_mem_v2
  import pipe_defs::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RA_W     = DEF_RA_W,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_in,
  input  logic               jump_in,
  input  logic               branch_in,
  input  logic               bne_in,
  input  logic               mem_read_in,
  input  logic               mem_to_reg_in,
  input  logic               mem_write_in,
  input  logic               reg_write_in,
  input  logic [1:0]         reg_dst_in,
  input  logic               zero_in,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [DATA_W-1:0]  link_pc_in,
  input  logic [INSTR_W-1:0] instru_in,
  output logic               valid,
  output logic               jump,
  output logic               branch,
  output logic               bne,
  output logic               mem_read,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic               reg_write,
  output logic               zero,
  output logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  store_data,
  output logic [DATA_W-1:0]  link_pc,
  output logic [RA_W-1:0]    write_reg,
  output logic [INSTR_W-1:0] instru,
  output logic               fwd_valid,
  output logic [RA_W-1:0]    fwd_addr,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic               valid;
    logic               jump;
    logic               branch;
    logic               bne;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               reg_write;
    logic               zero;
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  store_data;
    logic [DATA_W-1:0]  link_pc;
    logic [RA_W-1:0]    write_reg;
    logic [INSTR_W-1:0] instru;
  } stage_t;

  stage_t          stage_q, stage_d;
  logic [RA_W-1:0] dest;
  logic            dest_is_zero;

  wdest_sel #(
    .RA_W     (RA_W),
    .LINK_REG (LINK_REG)
  ) u_wdest_sel (
    .reg_dst      (reg_dst_in),
    .instr        (instru_in[RT_HI:RD_LO]),
    .dest         (dest),
    .dest_is_zero (dest_is_zero)
  );

  // Next stage contents: flush inserts an all-zero bubble, stall holds,
  // otherwise load with controls gated by valid_in
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid      = valid_in;
      stage_d.jump       = jump_in       & valid_in;
      stage_d.branch     = branch_in     & valid_in;
      stage_d.bne        = bne_in        & valid_in;
      stage_d.mem_read   = mem_read_in   & valid_in;
      stage_d.mem_to_reg = mem_to_reg_in & valid_in;
      stage_d.mem_write  = mem_write_in  & valid_in;
      // $0 is never written; the index itself is still carried
      stage_d.reg_write  = reg_write_in  & valid_in & ~dest_is_zero;
      stage_d.zero       = zero_in;
      stage_d.alu_result = alu_result_in;
      stage_d.store_data = store_data_in;
      stage_d.link_pc    = link_pc_in;
      stage_d.write_reg  = dest;
      stage_d.instru     = instru_in;
    end
  end

  // Stage register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign valid      = stage_q.valid;
  assign jump       = stage_q.jump;
  assign branch     = stage_q.branch;
  assign bne        = stage_q.bne;
  assign mem_read   = stage_q.mem_read;
  assign mem_to_reg = stage_q.mem_to_reg;
  assign mem_write  = stage_q.mem_write;
  assign reg_write  = stage_q.reg_write;
  assign zero       = stage_q.zero;
  assign alu_result = stage_q.alu_result;
  assign store_data = stage_q.store_data;
  assign link_pc    = stage_q.link_pc;
  assign write_reg  = stage_q.write_reg;
  assign instru     = stage_q.instru;
  assign fwd_valid  = stage_q.reg_write;
  assign fwd_addr   = stage_q.write_reg;

`ifdef EX_MEM_PERF_CNT_EN
  logic             bubble_ev, stall_ev;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign bubble_ev = flush | (~stall & ~valid_in);
  assign stall_ev  = stall & ~flush;

  // Saturating event counters
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bubble_ev && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
    if (stall_ev  && (stall_cnt_q  != '1)) stall_cnt_d  = stall_cnt_q  + 1'b1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pr_ex_mem_v2.sv
// Directed scoreboard bench for pr_ex_mem_v2 (CNT_W=2 to exercise saturation).
module tb_pr_ex_mem_v2;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in;
  logic        jump_in, branch_in, bne_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in;
  logic [1:0]  reg_dst_in;
  logic        zero_in;
  logic [31:0] alu_result_in, store_data_in, link_pc_in, instru_in;
  logic        valid, jump, branch, bne, mem_read, mem_to_reg, mem_write, reg_write, zero;
  logic [31:0] alu_result, store_data, link_pc, instru;
  logic [4:0]  write_reg, fwd_addr;
  logic        fwd_valid;
  logic [1:0]  bubble_cnt, stall_cnt;

  always #5 clk = ~clk;

  pr_ex_mem_v2 #(
    .DATA_W(32), .INSTR_W(32), .RA_W(5), .LINK_REG(31), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .jump_in(jump_in), .branch_in(branch_in), .bne_in(bne_in),
    .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .reg_dst_in(reg_dst_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .link_pc_in(link_pc_in), .instru_in(instru_in),
    .valid(valid), .jump(jump), .branch(branch), .bne(bne), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .reg_write(reg_write),
    .zero(zero), .alu_result(alu_result), .store_data(store_data),
    .link_pc(link_pc), .write_reg(write_reg), .instru(instru),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  // controls ordered {jump, branch, bne, mem_read, mem_to_reg, mem_write, reg_write}
  typedef struct packed {
    logic        valid;
    logic [6:0]  ctrl;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] lpc;
    logic [4:0]  wr;
    logic [31:0] ins;
    logic        fwd_v;
    logic [4:0]  fwd_a;
    logic [1:0]  bc;
    logic [1:0]  sc;
  } obs_t;

  obs_t exp_q[$];
  int   id_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   bc_m = 0;
  int   sc_m = 0;

  function automatic obs_t mk(input logic v, input logic [6:0] c, input logic z,
                              input logic [31:0] a, input logic [31:0] s,
                              input logic [31:0] l, input logic [4:0] w,
                              input logic [31:0] i);
    obs_t o;
    o = '0;
    o.valid = v; o.ctrl = c; o.zero = z; o.alu = a; o.sd = s; o.lpc = l;
    o.wr = w; o.ins = i;
    return o;
  endfunction

  // Drive one edge worth of stimulus and queue the expected post-edge state
  task automatic vec(input int id, input logic r, input logic s, input logic f,
                     input logic vin, input logic [6:0] c, input logic [1:0] rd,
                     input logic z, input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] l, input logic [31:0] i, input obs_t e);
    obs_t x;
    @(negedge clk);
    rst = r; stall = s; flush = f; valid_in = vin;
    {jump_in, branch_in, bne_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in} = c;
    reg_dst_in = rd; zero_in = z; alu_result_in = a; store_data_in = sd;
    link_pc_in = l; instru_in = i;
    if (r) begin
      bc_m = 0; sc_m = 0;
    end else if (f) begin
      if (bc_m < 3) bc_m++;
    end else if (s) begin
      if (sc_m < 3) sc_m++;
    end else if (!vin) begin
      if (bc_m < 3) bc_m++;
    end
    x = e;
    x.fwd_v = e.ctrl[0];
    x.fwd_a = e.wr;
`ifdef EX_MEM_PERF_CNT_EN
    x.bc = 2'(bc_m);
    x.sc = 2'(sc_m);
`else
    x.bc = 2'b00;
    x.sc = 2'b00;
`endif
    exp_q.push_back(x);
    id_q.push_back(id);
  endtask

  // Monitor: compare the registered outputs just after each rising edge
  initial begin
    obs_t e, act;
    int   id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        act.valid = valid;
        act.ctrl  = {jump, branch, bne, mem_read, mem_to_reg, mem_write, reg_write};
        act.zero  = zero; act.alu = alu_result; act.sd = store_data;
        act.lpc   = link_pc; act.wr = write_reg; act.ins = instru;
        act.fwd_v = fwd_valid; act.fwd_a = fwd_addr;
        act.bc    = bubble_cnt; act.sc = stall_cnt;
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL vec%0d got=%h expected=%h", id, act, e);
        end else begin
          $display("vec%0d ok valid=%b ctrl=%b wr=%0d bc=%0d sc=%0d",
                   id, act.valid, act.ctrl, act.wr, act.bc, act.sc);
        end
      end
    end
  end

  initial begin
    obs_t z0, e1, e4;
    z0 = '0;
    e1 = mk(1'b1, 7'b0000001, 1'b0, 32'h55, 32'h0, 32'h0, 5'd8, 32'h012A4020);
    e4 = mk(1'b1, 7'b0000010, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 5'd11, 32'hAC0B0004);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    {jump_in, branch_in, bne_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in} = '0;
    reg_dst_in = 2'b00; zero_in = 1'b0; alu_result_in = '0; store_data_in = '0;
    link_pc_in = '0; instru_in = '0;

    // reset state
    vec(0, 1, 0, 0, 0, 7'h00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0, z0);
    // rd destination load
    vec(1, 0, 0, 0, 1, 7'b0000001, 2'b01, 0, 32'h55, 32'h0, 32'h0, 32'h012A4020, e1);
    // JAL: link register and link PC
    vec(2, 0, 0, 0, 1, 7'b1000001, 2'b10, 0, 32'h0, 32'h0, 32'h00400010, 32'h0C100004,
        mk(1'b1, 7'b1000001, 1'b0, 32'h0, 32'h0, 32'h00400010, 5'd31, 32'h0C100004));
    // write to $0 squashed
    vec(3, 0, 0, 0, 1, 7'b0000001, 2'b00, 0, 32'h7, 32'h0, 32'h0, 32'h00004020,
        mk(1'b1, 7'b0000000, 1'b0, 32'h7, 32'h0, 32'h0, 5'd0, 32'h00004020));
    // store load
    vec(4, 0, 0, 0, 1, 7'b0000010, 2'b00, 0, 32'h100, 32'hDEADBEEF, 32'h0, 32'hAC0B0004, e4);
    // three stalls with noisy inputs hold the store
    for (int k = 0; k < 3; k++)
      vec(5 + k, 0, 1, 0, 1, 7'h7F, 2'b01, 1, 32'hFFFFFFFF, 32'h12345678, 32'h9, 32'hFFFFFFFF, e4);
    // flush wins over stall
    vec(8, 0, 1, 1, 1, 7'h7F, 2'b01, 1, 32'h1, 32'h2, 32'h3, 32'h012A4020, z0);
    // valid_in=0 bubble keeps data, kills controls
    vec(9, 0, 0, 0, 0, 7'h7F, 2'b01, 1, 32'hAA, 32'h11, 32'h22, 32'h012A4020,
        mk(1'b0, 7'b0000000, 1'b1, 32'hAA, 32'h11, 32'h22, 5'd8, 32'h012A4020));
    // reserved reg_dst=11 -> rt, mem_read+mem_write together
    vec(10, 0, 0, 0, 1, 7'b0111111, 2'b11, 1, 32'h1234, 32'h5, 32'h0, 32'h8D2A0000,
        mk(1'b1, 7'b0111111, 1'b1, 32'h1234, 32'h5, 32'h0, 5'd10, 32'h8D2A0000));
    // reset beats stall
    vec(11, 1, 1, 0, 1, 7'h7F, 2'b01, 1, 32'h1, 32'h2, 32'h3, 32'h012A4020, z0);
    // reload, then five stalls to saturate the stall counter
    vec(12, 0, 0, 0, 1, 7'b0000001, 2'b01, 0, 32'h55, 32'h0, 32'h0, 32'h012A4020, e1);
    for (int k = 0; k < 5; k++)
      vec(13 + k, 0, 1, 0, 0, 7'h00, 2'b10, 0, 32'h0, 32'h0, 32'h0, 32'h0, e1);
    // plain flush
    vec(18, 0, 0, 1, 1, 7'h7F, 2'b01, 1, 32'h1, 32'h2, 32'h3, 32'h012A4020, z0);

    @(negedge clk);
    rst = 1'b0; stall = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
